// File: rtl/memory_stage_pkg.sv
// Shared constants for the memory stage: data/opcode widths, MIPS load/store
// opcodes and the access-size encoding used by decode and load extension.
package memory_stage_pkg;

  localparam int DWIDTH       = 32;
  localparam int OPCODE_WIDTH = 6;

  localparam logic [OPCODE_WIDTH-1:0] OP_LB  = 6'h20;
  localparam logic [OPCODE_WIDTH-1:0] OP_LH  = 6'h21;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW  = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_LBU = 6'h24;
  localparam logic [OPCODE_WIDTH-1:0] OP_LHU = 6'h25;
  localparam logic [OPCODE_WIDTH-1:0] OP_SB  = 6'h28;
  localparam logic [OPCODE_WIDTH-1:0] OP_SH  = 6'h29;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } acc_size_e;

endpackage

// File: rtl/memory_stage_data_memory.sv
// Word-organised data RAM: synchronous registered read, per-byte write enables,
// contents never reset.
module data_memory
  import memory_stage_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic              re,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: decodes byte/half/word loads and stores, checks
// alignment, drives the data RAM and registers the result for write-back.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int AWIDTH = 10
) (
  input  logic                    ms_i_clk,
  input  logic                    ms_i_rst_n,
  input  logic                    ms_i_ce,
  input  logic [OPCODE_WIDTH-1:0] ms_i_opcode,
  input  logic [DWIDTH-1:0]       ms_i_alu_value,
  input  logic [DWIDTH-1:0]       ms_i_data_rt,
  input  logic                    ms_i_stall,
  input  logic                    ms_i_flush,
  output logic                    ms_o_ce,
  output logic [OPCODE_WIDTH-1:0] ms_o_opcode,
  output logic [DWIDTH-1:0]       ms_o_data,
  output logic                    ms_o_is_load,
  output logic                    ms_o_misaligned
);

  logic              is_load, is_store, sign_ext, misaligned;
  acc_size_e         size;
  logic [1:0]        offset;
  logic [AWIDTH-1:0] word_addr;
  logic              accept, mem_we, mem_re;
  logic [3:0]        mem_be;
  logic [DWIDTH-1:0] mem_wdata, mem_rdata;

  logic [DWIDTH-1:0] data_q;
  logic [1:0]        offset_q;
  acc_size_e         size_q;
  logic              sign_ext_q;
  logic [DWIDTH-1:0] load_val;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;

  assign offset    = ms_i_alu_value[1:0];
  assign word_addr = ms_i_alu_value[AWIDTH+1:2];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sign_ext = 1'b0;
    size     = SZ_NONE;
    case (ms_i_opcode)
      OP_LB:  begin is_load  = 1'b1; size = SZ_BYTE; sign_ext = 1'b1; end
      OP_LH:  begin is_load  = 1'b1; size = SZ_HALF; sign_ext = 1'b1; end
      OP_LW:  begin is_load  = 1'b1; size = SZ_WORD; end
      OP_LBU: begin is_load  = 1'b1; size = SZ_BYTE; end
      OP_LHU: begin is_load  = 1'b1; size = SZ_HALF; end
      OP_SB:  begin is_store = 1'b1; size = SZ_BYTE; end
      OP_SH:  begin is_store = 1'b1; size = SZ_HALF; end
      OP_SW:  begin is_store = 1'b1; size = SZ_WORD; end
      default: ;
    endcase
  end

  assign misaligned = ((size == SZ_HALF) && offset[0]) ||
                      ((size == SZ_WORD) && (offset != 2'b00));

  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = ms_i_data_rt;
    case (size)
      SZ_BYTE: begin
        mem_be    = 4'b0001 << offset;
        mem_wdata = {4{ms_i_data_rt[7:0]}};
      end
      SZ_HALF: begin
        mem_be    = offset[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{ms_i_data_rt[15:0]}};
      end
      SZ_WORD: mem_be = 4'b1111;
      default: ;
    endcase
  end

  assign accept = ms_i_ce && !ms_i_flush && !ms_i_stall;
  // Gating with reset keeps a store from landing on the edge where reset is asserted.
  assign mem_we = accept && is_store && !misaligned && ms_i_rst_n;
  assign mem_re = accept && is_load && !misaligned;

  data_memory #(.DEPTH(DEPTH), .AWIDTH(AWIDTH)) u_data_memory (
    .clk   (ms_i_clk),
    .we    (mem_we),
    .be    (mem_be),
    .re    (mem_re),
    .addr  (word_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge ms_i_clk or negedge ms_i_rst_n) begin
    if (!ms_i_rst_n) begin
      ms_o_ce         <= 1'b0;
      ms_o_opcode     <= '0;
      data_q          <= '0;
      ms_o_is_load    <= 1'b0;
      ms_o_misaligned <= 1'b0;
      offset_q        <= '0;
      size_q          <= SZ_NONE;
      sign_ext_q      <= 1'b0;
    end else if (ms_i_flush || (!ms_i_stall && !ms_i_ce)) begin
      ms_o_ce         <= 1'b0;
      ms_o_opcode     <= '0;
      data_q          <= '0;
      ms_o_is_load    <= 1'b0;
      ms_o_misaligned <= 1'b0;
      offset_q        <= '0;
      size_q          <= SZ_NONE;
      sign_ext_q      <= 1'b0;
    end else if (!ms_i_stall) begin
      ms_o_ce         <= 1'b1;
      ms_o_opcode     <= ms_i_opcode;
      data_q          <= misaligned ? '0 : ms_i_alu_value;
      ms_o_is_load    <= is_load && !misaligned;
      ms_o_misaligned <= misaligned;
      offset_q        <= offset;
      size_q          <= size;
      sign_ext_q      <= sign_ext;
    end
  end

  // Lane select works on the registered offset so the RAM output feeds straight through.
  always_comb begin
    load_byte = mem_rdata[offset_q*8 +: 8];
    load_half = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_val = {{24{sign_ext_q & load_byte[7]}}, load_byte};
      SZ_HALF: load_val = {{16{sign_ext_q & load_half[15]}}, load_half};
      default: load_val = mem_rdata;
    endcase
  end

  assign ms_o_data = ms_o_is_load ? load_val : data_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: loads/stores, alignment, stall/flush,
// address aliasing and asynchronous reset, against hand-computed values.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam logic [5:0] OP_ADDI = 6'h08;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] alu_value = '0;
  logic [31:0] data_rt = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        o_ce;
  logic [5:0]  o_opcode;
  logic [31:0] o_data;
  logic        o_is_load;
  logic        o_misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  memory_stage #(.DEPTH(1024), .AWIDTH(10)) dut (
    .ms_i_clk        (clk),
    .ms_i_rst_n      (rst_n),
    .ms_i_ce         (ce),
    .ms_i_opcode     (opcode),
    .ms_i_alu_value  (alu_value),
    .ms_i_data_rt    (data_rt),
    .ms_i_stall      (stall),
    .ms_i_flush      (flush),
    .ms_o_ce         (o_ce),
    .ms_o_opcode     (o_opcode),
    .ms_o_data       (o_data),
    .ms_o_is_load    (o_is_load),
    .ms_o_misaligned (o_misaligned)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt);
    ce        = 1'b1;
    opcode    = op;
    alu_value = addr;
    data_rt   = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic exp_ce, input logic [31:0] exp_data,
                           input logic exp_load, input logic exp_mis);
    check_val({tag, ".ce"},   {31'b0, o_ce},         {31'b0, exp_ce});
    check_val({tag, ".data"}, o_data,                exp_data);
    check_val({tag, ".load"}, {31'b0, o_is_load},    {31'b0, exp_load});
    check_val({tag, ".mis"},  {31'b0, o_misaligned}, {31'b0, exp_mis});
  endtask

  initial begin
    #12;
    check_out("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    check_val("reset.opcode", {26'b0, o_opcode}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // word store then load
    @(posedge clk); #1;
    issue(OP_SW, 32'h10, 32'hDEADBEEF);
    check_out("sw10", 1'b1, 32'h10, 1'b0, 1'b0);
    check_val("sw10.opcode", {26'b0, o_opcode}, {26'b0, OP_SW});
    issue(OP_LW, 32'h10, 32'h0);
    check_out("lw10", 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);

    // byte store, signed/unsigned byte loads, neighbours intact
    issue(OP_SB, 32'h13, 32'h12345680);
    check_out("sb13", 1'b1, 32'h13, 1'b0, 1'b0);
    issue(OP_LB, 32'h13, 32'h0);
    check_out("lb13", 1'b1, 32'hFFFFFF80, 1'b1, 1'b0);
    issue(OP_LBU, 32'h13, 32'h0);
    check_out("lbu13", 1'b1, 32'h00000080, 1'b1, 1'b0);
    issue(OP_LW, 32'h10, 32'h0);
    check_val("lw10_after_sb", o_data, 32'h80ADBEEF);
    issue(OP_LBU, 32'h11, 32'h0);
    check_val("lbu11", o_data, 32'h000000BE);

    // misaligned halfword store leaves memory alone
    issue(OP_SW, 32'h20, 32'h11223344);
    issue(OP_SH, 32'h21, 32'h0000AAAA);
    check_out("sh21", 1'b1, 32'h0, 1'b0, 1'b1);
    issue(OP_LW, 32'h20, 32'h0);
    check_out("lw20", 1'b1, 32'h11223344, 1'b1, 1'b0);
    issue(OP_LH, 32'h22, 32'h0);
    check_val("lh22_pos", o_data, 32'h00001122);
    issue(OP_SH, 32'h22, 32'hFFFF8001);
    issue(OP_LH, 32'h22, 32'h0);
    check_val("lh22_neg", o_data, 32'hFFFF8001);
    issue(OP_LHU, 32'h22, 32'h0);
    check_val("lhu22", o_data, 32'h00008001);
    issue(OP_LHU, 32'h20, 32'h0);
    check_val("lhu20", o_data, 32'h00003344);
    issue(OP_LW, 32'h22, 32'h0);
    check_out("lw22_mis", 1'b1, 32'h0, 1'b0, 1'b1);

    // non-memory op and ce low
    issue(OP_ADDI, 32'h1234, 32'h5);
    check_out("addi", 1'b1, 32'h1234, 1'b0, 1'b0);
    ce = 1'b0;
    @(posedge clk); #1;
    check_out("ce_low", 1'b0, 32'h0, 1'b0, 1'b0);

    // stalled store squashed by flush: no write
    issue(OP_SW, 32'h30, 32'h00000000);
    issue(OP_ADDI, 32'h1234, 32'h0);
    opcode = OP_SW; alu_value = 32'h30; data_rt = 32'hCAFEF00D; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_out("stall_hold", 1'b1, 32'h1234, 1'b0, 1'b0);
      check_val("stall_hold.opcode", {26'b0, o_opcode}, {26'b0, OP_ADDI});
    end
    flush = 1'b1;
    @(posedge clk); #1;
    check_out("flush_stall", 1'b0, 32'h0, 1'b0, 1'b0);
    flush = 1'b0; stall = 1'b0;
    issue(OP_LW, 32'h30, 32'h0);
    check_val("lw30_no_write", o_data, 32'h00000000);

    // stalled store committed once stall drops
    issue(OP_ADDI, 32'h1234, 32'h0);
    opcode = OP_SW; alu_value = 32'h30; data_rt = 32'hCAFEF00D; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("stall2_hold", o_data, 32'h1234);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    check_out("stall_release", 1'b1, 32'h30, 1'b0, 1'b0);
    issue(OP_LW, 32'h30, 32'h0);
    check_val("lw30_written", o_data, 32'hCAFEF00D);

    // aliasing: 0x1010 wraps to word 4
    issue(OP_SW, 32'h1010, 32'h55AA55AA);
    check_val("sw1010.data", o_data, 32'h1010);
    issue(OP_LW, 32'h10, 32'h0);
    check_val("alias_lw10", o_data, 32'h55AA55AA);

    // async reset mid-cycle kills pending store
    issue(OP_SW, 32'h40, 32'h00000000);
    opcode = OP_SW; alu_value = 32'h40; data_rt = 32'h77777777; ce = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 32'h0, 1'b0, 1'b0);
    check_val("async_rst.opcode", {26'b0, o_opcode}, 32'h0);
    @(posedge clk); #1;
    check_out("rst_edge", 1'b0, 32'h0, 1'b0, 1'b0);
    ce = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_LW, 32'h40, 32'h0);
    check_out("lw40_after_rst", 1'b1, 32'h00000000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline memory stage that sits directly downstream of the execute stage. It captures execute's result (`ce`, opcode, ALU value) together with the store operand and performs MIPS byte/half/word loads and stores against an internal word-organised data memory. It presents a registered result to the write-back stage, with stall and flush controls for the hazard unit.

## Interface
Parameters:
- `DEPTH`, default 1024: data memory size in 32-bit words; must be a power of two.
- `AWIDTH`, default 10: word-address width, equal to log2(`DEPTH`).

Ports:
- `ms_i_clk`, input, 1: clock; all state updates on the rising edge.
- `ms_i_rst_n`, input, 1: reset, asynchronous and active-low.
- `ms_i_ce`, input, 1: execute result valid (execute's `es_o_ce`).
- `ms_i_opcode`, input, `OPCODE_WIDTH`: instruction opcode (execute's `es_o_opcode`).
- `ms_i_alu_value`, input, `DWIDTH`: ALU result; this is the byte address for loads and stores (execute's `es_o_alu_value`).
- `ms_i_data_rt`, input, `DWIDTH`: store data, forwarded rt.
- `ms_i_stall`, input, 1: hold the stage.
- `ms_i_flush`, input, 1: squash the incoming instruction.
- `ms_o_ce`, output, 1: result valid to write-back.
- `ms_o_opcode`, output, `OPCODE_WIDTH`: registered opcode.
- `ms_o_data`, output, `DWIDTH`: load data (extended) or pass-through ALU value.
- `ms_o_is_load`, output, 1: `ms_o_data` came from memory.
- `ms_o_misaligned`, output, 1: the captured access was misaligned; no write was performed and data is 0.

## Operation
Opcode decode uses the shared header constants:
- Loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
- Stores: SB 0x28, SH 0x29, SW 0x2B.
- Any other opcode is a non-memory op.

Addressing:
- Word index = `ms_i_alu_value[AWIDTH+1:2]`.
- Upper address bits are ignored, so addresses wrap modulo `DEPTH*4`.
- Byte offset = bits [1:0]; little-endian lanes, byte 0 = bits [7:0].

Alignment:
- Halfword accesses require offset bit 0 = 0.
- Word accesses require offset = 0.
- A violation sets `ms_o_misaligned`, suppresses the write, and forces `ms_o_data` = 0.

Stores:
- Byte-enable write: SB writes one lane, SH writes two lanes, SW writes four.
- Store data is taken from the low bits of rt, shifted into the addressed lane.
- `ms_o_data` = `ms_i_alu_value` (the address).

Loads:
- LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.

Non-memory ops: `ms_o_data` = `ms_i_alu_value`, and `ms_o_is_load` = 0.

Capture conditions (priority order, top wins):
- `ms_i_flush`: outputs become invalid (`ce`, opcode, data, flags all 0); no memory write.
- `ms_i_stall`: all output registers hold; no memory write, even if the held instruction is a store.
- `ms_i_ce` = 0: same as flush.
- Otherwise: capture the instruction and perform the access.

Reset:
- All outputs are 0 while `ms_i_rst_n` = 0.
- Memory contents are not reset.
- Reset asserted mid-store at the clock edge: the write is not performed.

## Timing
- An instruction is accepted at rising edge N. Its store is committed at edge N; its outputs are valid from N+1 until the next capture edge.
- Load latency is one cycle through a synchronous memory read registered at edge N. Lane select and extension use the registered offset and opcode, so `ms_o_data` is valid in cycle N+1 with no extra bubble.
- A store at edge N followed by a load of the same word at edge N+1 returns the new data (write-before-read across cycles).
- Same-cycle read/write cannot occur, because there is one access per cycle.
- Outputs are held stable for the whole of every stalled cycle.
- Deasserting the flush takes effect at the next edge.

## Structure
- Opcode constants go in the shared header: `OP_LB`, `OP_LH`, `OP_LW`, `OP_LBU`, `OP_LHU`, `OP_SB`, `OP_SH`, `OP_SW`. `DWIDTH` and `OPCODE_WIDTH` are already defined there.
- One sub-module, `data_memory`: a word array with a synchronous read port, a 4-bit byte-enable write, and no reset.
- `memory_stage` holds decode, alignment check, lane shift, the output registers, and the load extension logic.

## Test plan
- SW 0xDEADBEEF to address 0x10, then LW from 0x10: `ms_o_data` = 0xDEADBEEF, `ms_o_is_load` = 1, in the cycle after the load is accepted.
- SB 0x80 to address 0x13, then LB 0x13 and LBU 0x13: 0xFFFFFF80 and 0x00000080 respectively; the other bytes of the word are unchanged.
- SH to address 0x21: `ms_o_misaligned` = 1, `ms_o_data` = 0, and a following LW 0x20 shows the memory unchanged.
- Store issued while `ms_i_stall` = 1 for 3 cycles: no write occurs and outputs hold; the write happens once, at the edge where stall drops. Separately, flush together with stall yields `ms_o_ce` = 0.
- ADD with `ms_i_alu_value` = 0x1234: `ms_o_data` = 0x1234, `ms_o_is_load` = 0. Address 0x1010 with `DEPTH` = 1024 aliases to word 4.
- Assert `ms_i_rst_n` low asynchronously mid-cycle: all outputs are 0 immediately; a store pending at that edge is not written.
